// File: rtl/arbitro_memoria_dados.sv
// arbitro_memoria_dados: shares one single-port data memory between the CPU
// datapath and the I/O/DMA port using req/ack handshakes on each side.
// Every service cycle drives one access onto the memory port. Read data is
// registered and returned together with a one-cycle ack.
// Optional macro ARB_PRIORIDADE_FIXA_CPU_EN: the CPU wins every tie (fixed
// priority). When the macro is not defined, ties are resolved round-robin
// against the last port served.
//
// state     | meaning
// OCIOSO    | no access on the memory port; arbitrate at every edge
// SERVE_CPU | latched CPU access driven onto the memory port (one cycle)
// SERVE_IO  | latched I/O access driven onto the memory port (one cycle)
module arbitro_memoria_dados #(
  parameter int LARGURA_DADO = 32,
  parameter int LARGURA_END  = 26,
  parameter int PROFUNDIDADE = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [LARGURA_END-1:0]  cpu_endereco,
  input  logic [LARGURA_DADO-1:0] cpu_dado_in,
  output logic                    cpu_ack,
  output logic [LARGURA_DADO-1:0] cpu_dado_out,
  output logic                    cpu_erro,
  input  logic                    io_req,
  input  logic                    io_we,
  input  logic [LARGURA_END-1:0]  io_endereco,
  input  logic [LARGURA_DADO-1:0] io_dado_in,
  output logic                    io_ack,
  output logic [LARGURA_DADO-1:0] io_dado_out,
  output logic                    io_erro,
  output logic [LARGURA_END-1:0]  mem_endereco,
  output logic                    mem_memWrite,
  output logic [LARGURA_DADO-1:0] mem_dado_Escrito,
  input  logic [LARGURA_DADO-1:0] mem_dado_Lido
);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    SERVE_CPU = 2'd1,
    SERVE_IO  = 2'd2
  } estado_t;

  estado_t                 estado_q, estado_d;
  logic                    we_q, we_d;
  logic [LARGURA_END-1:0]  end_q, end_d;
  logic [LARGURA_DADO-1:0] dado_q, dado_d;
  logic                    cpu_ack_q, cpu_ack_d;
  logic                    cpu_erro_q, cpu_erro_d;
  logic [LARGURA_DADO-1:0] cpu_dado_out_q, cpu_dado_out_d;
  logic                    io_ack_q, io_ack_d;
  logic                    io_erro_q, io_erro_d;
  logic [LARGURA_DADO-1:0] io_dado_out_q, io_dado_out_d;

  logic serve_cpu, serve_io, em_faixa;
  logic cpu_eleg, io_eleg, ganha_cpu, ganha_io;

  assign serve_cpu = (estado_q == SERVE_CPU);
  assign serve_io  = (estado_q == SERVE_IO);
  assign em_faixa  = (end_q < LARGURA_END'(PROFUNDIDADE));

  // A port is not re-granted while it is being served (its req is still the
  // request in progress) nor while its ack is high.
  assign cpu_eleg = cpu_req & ~cpu_ack_q & ~serve_cpu;
  assign io_eleg  = io_req  & ~io_ack_q  & ~serve_io;

`ifdef ARB_PRIORIDADE_FIXA_CPU_EN
  assign ganha_cpu = cpu_eleg;
`else
  // ultimo: 0 = CPU served last, 1 = IO served last.
  logic ultimo_q, ultimo_d;

  assign ganha_cpu = cpu_eleg & (~io_eleg | ultimo_q);

  // Remember the port granted at this edge for the next tie.
  always_comb begin
    ultimo_d = ultimo_q;
    if (ganha_cpu)     ultimo_d = 1'b0;
    else if (io_eleg)  ultimo_d = 1'b1;
  end

  // Resets to IO so the CPU wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ultimo_q <= 1'b1;
    else       ultimo_q <= ultimo_d;
  end
`endif

  assign ganha_io = io_eleg & ~ganha_cpu;

  // Next state, latch of the granted request, and completion of the access.
  always_comb begin
    estado_d       = OCIOSO;
    we_d           = we_q;
    end_d          = end_q;
    dado_d         = dado_q;
    cpu_ack_d      = 1'b0;
    cpu_erro_d     = 1'b0;
    cpu_dado_out_d = cpu_dado_out_q;
    io_ack_d       = 1'b0;
    io_erro_d      = 1'b0;
    io_dado_out_d  = io_dado_out_q;

    if (serve_cpu) begin
      cpu_ack_d      = 1'b1;
      cpu_erro_d     = ~em_faixa;
      cpu_dado_out_d = em_faixa ? mem_dado_Lido : '0;
    end
    if (serve_io) begin
      io_ack_d      = 1'b1;
      io_erro_d     = ~em_faixa;
      io_dado_out_d = em_faixa ? mem_dado_Lido : '0;
    end

    if (ganha_cpu) begin
      estado_d = SERVE_CPU;
      we_d     = cpu_we;
      end_d    = cpu_endereco;
      dado_d   = cpu_dado_in;
    end else if (ganha_io) begin
      estado_d = SERVE_IO;
      we_d     = io_we;
      end_d    = io_endereco;
      dado_d   = io_dado_in;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado_q <= OCIOSO;
    else       estado_q <= estado_d;
  end

  // Latched request and registered responses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q           <= 1'b0;
      end_q          <= '0;
      dado_q         <= '0;
      cpu_ack_q      <= 1'b0;
      cpu_erro_q     <= 1'b0;
      cpu_dado_out_q <= '0;
      io_ack_q       <= 1'b0;
      io_erro_q      <= 1'b0;
      io_dado_out_q  <= '0;
    end else begin
      we_q           <= we_d;
      end_q          <= end_d;
      dado_q         <= dado_d;
      cpu_ack_q      <= cpu_ack_d;
      cpu_erro_q     <= cpu_erro_d;
      cpu_dado_out_q <= cpu_dado_out_d;
      io_ack_q       <= io_ack_d;
      io_erro_q      <= io_erro_d;
      io_dado_out_q  <= io_dado_out_d;
    end
  end

  // Write enable comes straight from the state so reset removes it at once.
  assign mem_memWrite     = (serve_cpu | serve_io) & we_q & em_faixa;
  assign mem_endereco     = end_q;
  assign mem_dado_Escrito = dado_q;

  assign cpu_ack      = cpu_ack_q;
  assign cpu_erro     = cpu_erro_q;
  assign cpu_dado_out = cpu_dado_out_q;
  assign io_ack       = io_ack_q;
  assign io_erro      = io_erro_q;
  assign io_dado_out  = io_dado_out_q;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Bench for arbitro_memoria_dados: directed scenarios followed by random
// single and dual-port transactions, checked against a word-level model of
// memory contents and round-robin service order.
module tb_arbitro_memoria_dados;

  localparam logic [31:0] MEM_INI [16] = '{
    32'hA000_0000, 32'hA101_0101, 32'hA202_0202, 32'hA303_0303,
    32'hA404_0404, 32'hA505_0505, 32'hA606_0606, 32'hA707_0707,
    32'hA808_0808, 32'hA909_0909, 32'hAA0A_0A0A, 32'hAB0B_0B0B,
    32'hAC0C_0C0C, 32'hAD0D_0D0D, 32'hAE0E_0E0E, 32'hAF0F_0F0F};

  logic        clock, reset;
  logic        cpu_req, cpu_we, io_req, io_we;
  logic [25:0] cpu_endereco, io_endereco;
  logic [31:0] cpu_dado_in, io_dado_in;
  logic        cpu_ack, cpu_erro, io_ack, io_erro;
  logic [31:0] cpu_dado_out, io_dado_out;
  logic [25:0] mem_endereco;
  logic        mem_memWrite;
  logic [31:0] mem_dado_Escrito, mem_dado_Lido;

  logic [31:0] mem_bench [16] = MEM_INI;
  logic [31:0] modelo_mem [16];
  logic        ultimo_m;   // 1 = IO was the last port served
  int          checks = 0;
  int          errors = 0;

  arbitro_memoria_dados dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_endereco(cpu_endereco),
    .cpu_dado_in(cpu_dado_in), .cpu_ack(cpu_ack), .cpu_dado_out(cpu_dado_out),
    .cpu_erro(cpu_erro),
    .io_req(io_req), .io_we(io_we), .io_endereco(io_endereco),
    .io_dado_in(io_dado_in), .io_ack(io_ack), .io_dado_out(io_dado_out),
    .io_erro(io_erro),
    .mem_endereco(mem_endereco), .mem_memWrite(mem_memWrite),
    .mem_dado_Escrito(mem_dado_Escrito), .mem_dado_Lido(mem_dado_Lido));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory: combinational read, write on the rising edge.
  assign mem_dado_Lido = (mem_endereco < 26'd16) ? mem_bench[mem_endereco[3:0]]
                                                 : {6'h2B, mem_endereco};
  always @(posedge clock)
    if (mem_memWrite && mem_endereco < 26'd16)
      mem_bench[mem_endereco[3:0]] <= mem_dado_Escrito;

  task automatic verifica_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic verifica_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One access as seen by the memory: returns the word delivered to the
  // requester and applies the write to the model.
  function automatic logic [31:0] acesso(input logic we, input logic [25:0] a,
                                         input logic [31:0] d);
    logic [31:0] r;
    r = 32'h0;
    if (a < 26'd16) begin
      r = modelo_mem[a[3:0]];
      if (we) modelo_mem[a[3:0]] = d;
    end
    return r;
  endfunction

  // Issues one request per enabled port on the same edge; called right after
  // a falling edge with both ports idle. Checks five cycles exactly.
  task automatic transacao(input logic c_on, input logic c_we, input logic [25:0] c_end,
                           input logic [31:0] c_dd, input logic i_on, input logic i_we,
                           input logic [25:0] i_end, input logic [31:0] i_dd);
    int c_k, i_k;
    logic [31:0] c_exp, i_exp;
    logic c_ok, i_ok, exp_we;
    c_k = 0; i_k = 0; c_exp = 32'h0; i_exp = 32'h0;
    c_ok = (c_end < 26'd16);
    i_ok = (i_end < 26'd16);
    if (c_on && i_on) begin
      if (ultimo_m) begin c_k = 2; i_k = 3; end
      else          begin i_k = 2; c_k = 3; end
    end else begin
      if (c_on) c_k = 2;
      if (i_on) i_k = 2;
    end
    if (c_k == 2) begin
      c_exp = acesso(c_we, c_end, c_dd); ultimo_m = 1'b0;
      if (i_on) begin i_exp = acesso(i_we, i_end, i_dd); ultimo_m = 1'b1; end
    end else if (i_k == 2) begin
      i_exp = acesso(i_we, i_end, i_dd); ultimo_m = 1'b1;
      if (c_on) begin c_exp = acesso(c_we, c_end, c_dd); ultimo_m = 1'b0; end
    end
    cpu_req = c_on; cpu_we = c_we; cpu_endereco = c_end; cpu_dado_in = c_dd;
    io_req  = i_on; io_we  = i_we; io_endereco  = i_end; io_dado_in  = i_dd;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      exp_we = (k == c_k - 1 && c_we && c_ok) || (k == i_k - 1 && i_we && i_ok);
      verifica_b("mem_memWrite", mem_memWrite, exp_we);
      if (k == c_k - 1) begin
        verifica_w("mem_endereco_cpu", 32'(mem_endereco), 32'(c_end));
        verifica_w("mem_dado_Escrito_cpu", mem_dado_Escrito, c_dd);
        cpu_endereco = 26'($urandom); cpu_dado_in = $urandom; cpu_we = 1'($urandom);
      end
      if (k == i_k - 1) begin
        verifica_w("mem_endereco_io", 32'(mem_endereco), 32'(i_end));
        verifica_w("mem_dado_Escrito_io", mem_dado_Escrito, i_dd);
        io_endereco = 26'($urandom); io_dado_in = $urandom; io_we = 1'($urandom);
      end
      verifica_b("cpu_ack", cpu_ack, k == c_k);
      verifica_b("io_ack", io_ack, k == i_k);
      verifica_b("cpu_erro", cpu_erro, k == c_k && !c_ok);
      verifica_b("io_erro", io_erro, k == i_k && !i_ok);
      if (k == c_k) begin
        verifica_w("cpu_dado_out", cpu_dado_out, c_exp);
        cpu_req = 1'b0;
      end
      if (k == i_k) begin
        verifica_w("io_dado_out", io_dado_out, i_exp);
        io_req = 1'b0;
      end
    end
    cpu_req = 1'b0; io_req = 1'b0;
  endtask

  initial begin
    int ordem[$];
    int primeiro, modo;
    logic [25:0] a1, a2;

    for (int i = 0; i < 16; i++) modelo_mem[i] = MEM_INI[i];
    ultimo_m = 1'b1;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_endereco = '0; cpu_dado_in = '0;
    io_req  = 1'b0; io_we  = 1'b0; io_endereco  = '0; io_dado_in  = '0;
    repeat (2) @(negedge clock);
    verifica_b("rst_cpu_ack", cpu_ack, 1'b0);
    verifica_b("rst_io_ack", io_ack, 1'b0);
    verifica_b("rst_cpu_erro", cpu_erro, 1'b0);
    verifica_b("rst_io_erro", io_erro, 1'b0);
    verifica_w("rst_cpu_dado_out", cpu_dado_out, 32'h0);
    verifica_w("rst_io_dado_out", io_dado_out, 32'h0);
    verifica_b("rst_mem_memWrite", mem_memWrite, 1'b0);
    verifica_w("rst_mem_endereco", 32'(mem_endereco), 32'h0);
    verifica_w("rst_mem_dado_Escrito", mem_dado_Escrito, 32'h0);
    reset = 1'b0;

    // CPU write then read of word 3.
    transacao(1'b1, 1'b1, 26'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 26'd0, 32'h0);
    transacao(1'b1, 1'b0, 26'd3, 32'h0, 1'b0, 1'b0, 26'd0, 32'h0);
    verifica_w("cpu_read_back_3", modelo_mem[3], 32'hDEAD_BEEF);

    // IO write and read at the first out-of-range address.
    transacao(1'b0, 1'b0, 26'd0, 32'h0, 1'b1, 1'b1, 26'd16, 32'h5555_AAAA);
    transacao(1'b0, 1'b0, 26'd0, 32'h0, 1'b1, 1'b0, 26'd16, 32'h0);

    // Both requests held: services must alternate.
    primeiro = ultimo_m ? 0 : 1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_endereco = 26'd1;
    io_req  = 1'b1; io_we  = 1'b0; io_endereco  = 26'd2;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clock);
      if (cpu_ack) ordem.push_back(0);
      if (io_ack)  ordem.push_back(1);
      if (k == 8) begin cpu_req = 1'b0; io_req = 1'b0; end
    end
    verifica_b("ordem_tamanho", ordem.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++)
      verifica_w("ordem_servico", (i < ordem.size()) ? 32'(ordem[i]) : 32'hFFFF,
                 32'((i % 2 == 0) ? primeiro : 1 - primeiro));

    // IO holds req through its ack: one idle edge, then the second access.
    io_req = 1'b1; io_we = 1'b1; io_endereco = 26'd2; io_dado_in = 32'h0BAD_F00D;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      verifica_b("io_held_memWrite", mem_memWrite, k == 1 || k == 4);
      verifica_b("io_held_ack", io_ack, k == 2 || k == 5);
      if (k == 5) io_req = 1'b0;
    end
    void'(acesso(1'b1, 26'd2, 32'h0BAD_F00D));
    ultimo_m = 1'b1;
    verifica_w("io_held_word2", mem_bench[2], modelo_mem[2]);

    // Reset during SERVE_CPU of a write to word 5.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_endereco = 26'd5; cpu_dado_in = 32'h1234_5678;
    @(posedge clock);
    #2;
    verifica_b("pre_reset_memWrite", mem_memWrite, 1'b1);
    reset = 1'b1;
    #1;
    verifica_b("reset_async_memWrite", mem_memWrite, 1'b0);
    cpu_req = 1'b0;
    @(negedge clock);
    verifica_b("reset_no_ack", cpu_ack, 1'b0);
    reset = 1'b0;
    ultimo_m = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      verifica_b("post_reset_no_ack", cpu_ack, 1'b0);
    end
    verifica_w("reset_word5", mem_bench[5], modelo_mem[5]);
    transacao(1'b1, 1'b0, 26'd5, 32'h0, 1'b0, 1'b0, 26'd0, 32'h0);

    // Random traffic: single-port and simultaneous requests.
    for (int n = 0; n < 40; n++) begin
      modo = $urandom_range(0, 2);
      a1 = 26'($urandom_range(0, 19));
      a2 = 26'($urandom_range(0, 19));
      transacao(modo != 1, 1'($urandom), a1, $urandom,
                modo != 0, 1'($urandom), a2, $urandom);
    end
    for (int i = 0; i < 16; i++)
      verifica_w("final_mem", mem_bench[i], modelo_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
